ads5296a_top: RTL and testbench

ADS5296A_TOP -- requirements
Module: ads5296a_top

---
 rtl/ads5296a_top.sv | 162 ++++++++++++++++
 tb/tb_ads5296a_top.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ads5296a_top.sv
// Purpose: deserialise LANES serial ADC data lanes plus a frame clock into parallel words, with per-input delay taps and frame-pattern word alignment.
// Latency: the last bit of a word sampled at edge N appears on data_o (with a data_valid_o pulse) after edge N+1; tap loads apply from the next cycle.
// Backpressure: none; the serial stream is free-running and data_o is overwritten at every word boundary.
module ads5296a_top #(
  parameter int LANES    = 8,
  parameter int BITS     = 10,
  parameter int LOCK_CNT = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     adclk_i,
  input  logic [LANES-1:0]         dat_i,
  input  logic [5*(LANES+1)-1:0]   idelay_val_i,
  input  logic                     idelay_ld_i,
  output logic [LANES*BITS-1:0]    data_o,
  output logic                     data_valid_o,
  output logic                     bitslip_done
);

  // Frame input sits at index LANES of every per-input array below.
  localparam int NIN = LANES + 1;
  localparam int CW  = $clog2(BITS);
  localparam int MW  = $clog2(LOCK_CNT + 2);
  localparam logic [BITS-1:0] FRAME_PAT = {{(BITS/2){1'b1}}, {(BITS/2){1'b0}}};

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

  logic [1:0]                  rst_sync_q;
  logic                        arst_n;
  logic [NIN-1:0]              in_vec;
  logic [NIN-1:0][4:0]         tap_q;
  // Bit j holds the input delayed by j+1 cycles; 31 taps cover delays 1..31.
  logic [NIN-1:0][30:0]        dly_q;
  logic [NIN-1:0]              dl_d;
  logic [LANES-1:0][BITS-1:0]  lane_sr_q;
  logic [BITS-1:0]             frm_sr_q;
  logic [CW-1:0]               bit_cnt_q;
  logic [MW-1:0]               match_q;
  logic [MW-1:0]               match_d;
  logic                        miss_q;
  state_t                      state_q;
  logic [LANES*BITS-1:0]       data_q;
  logic                        valid_q;
  logic                        done_q;
  logic                        frm_match_d;
  logic                        boundary_d;

  assign in_vec       = {adclk_i, dat_i};
  assign arst_n       = rst_sync_q[1];
  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign bitslip_done = done_q;

  // Reset asserts immediately but is released only after two sys_clk edges.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Tap registers: all slices load together on the strobe.
  always_ff @(posedge sys_clk or negedge arst_n) begin
    if (!arst_n)          tap_q <= '0;
    else if (idelay_ld_i) tap_q <= idelay_val_i;
  end

  // Delay history per input, always shifting so a tap change reads valid history.
  always_ff @(posedge sys_clk or negedge arst_n) begin
    if (!arst_n) dly_q <= '0;
    else begin
      for (int k = 0; k < NIN; k++) dly_q[k] <= {dly_q[k][29:0], in_vec[k]};
    end
  end

  // Tap selection: tap 0 passes the live input straight through.
  always_comb begin
    dl_d = '0;
    for (int k = 0; k < NIN; k++) begin
      if (tap_q[k] == 5'd0) dl_d[k] = in_vec[k];
      else                  dl_d[k] = dly_q[k][tap_q[k] - 5'd1];
    end
  end

  // Word shift registers, newest bit at the LSB so the first bit ends at the MSB.
  always_ff @(posedge sys_clk or negedge arst_n) begin
    if (!arst_n) begin
      lane_sr_q <= '0;
      frm_sr_q  <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) lane_sr_q[k] <= {lane_sr_q[k][BITS-2:0], dl_d[k]};
      frm_sr_q <= {frm_sr_q[BITS-2:0], dl_d[LANES]};
    end
  end

  // Boundary: counter wrap, or a frame match while searching re-phases the counter.
  always_comb begin
    frm_match_d = (frm_sr_q == FRAME_PAT);
    boundary_d  = (bit_cnt_q == CW'(BITS-1)) || ((state_q == SEARCH) && frm_match_d);
    match_d     = match_q + MW'(1);
  end

  // Alignment FSM with registered word output, valid strobe and lock flag.
  always_ff @(posedge sys_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= SEARCH;
      bit_cnt_q <= '0;
      match_q   <= '0;
      miss_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (boundary_d) begin
        bit_cnt_q <= '0;
        data_q    <= lane_sr_q;
        valid_q   <= 1'b1;
        case (state_q)
          SEARCH: begin
            if (frm_match_d) begin
              state_q <= CONFIRM;
              match_q <= MW'(1);
            end
          end
          CONFIRM: begin
            if (!frm_match_d) begin
              state_q <= SEARCH;
              match_q <= '0;
            end else if (match_d >= MW'(LOCK_CNT)) begin
              state_q <= LOCKED;
              match_q <= match_d;
              miss_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              match_q <= match_d;
            end
          end
          LOCKED: begin
            // One bad frame word is tolerated; a second in a row drops lock.
            if (frm_match_d) begin
              miss_q <= 1'b0;
            end else if (miss_q) begin
              state_q <= SEARCH;
              match_q <= '0;
              miss_q  <= 1'b0;
              done_q  <= 1'b0;
            end else begin
              miss_q <= 1'b1;
            end
          end
          default: begin
            state_q <= SEARCH;
            match_q <= '0;
            done_q  <= 1'b0;
          end
        endcase
      end else begin
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ads5296a_top.sv
// Purpose: randomized scoreboard bench for ads5296a_top against a delayed-bit-stream reference model.
// Latency: expects each locked word one edge after its last bit is sampled.
// Backpressure: none; stimulus is a continuous serial stream.
module tb_ads5296a_top;

  localparam int L  = 8;
  localparam int B  = 10;
  localparam int W  = L * B;
  localparam int TW = 5 * (L + 1);
  localparam int HD = 32768;
  localparam logic [B-1:0] PAT = 10'b1111100000;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          adclk_i = 1'b0;
  logic [L-1:0]  dat_i = '0;
  logic [TW-1:0] idelay_val_i = '0;
  logic          idelay_ld_i = 1'b0;
  logic [W-1:0]  data_o;
  logic          data_valid_o;
  logic          bitslip_done;

  ads5296a_top #(.LANES(L), .BITS(B), .LOCK_CNT(2)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .adclk_i      (adclk_i),
    .dat_i        (dat_i),
    .idelay_val_i (idelay_val_i),
    .idelay_ld_i  (idelay_ld_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .bitslip_done (bitslip_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int           n;
    logic [W-1:0] exp_w;
    bit           must;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           edge_n = 0;
  int           cur_tap[L];
  int           lane_off[L] = '{0, 1, 3, 5, 7, 11, 13, 17};
  logic [L-1:0] in_h [0:HD-1];
  logic [L-1:0] d_h  [0:HD-1];

  always @(posedge sys_clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp_v);
    end
  endtask

  // Delayed stream bit of lane k at cycle c, as the reference sees it.
  function automatic logic get_d(input int c, input int k);
    if (c < 0) return 1'b0;
    return d_h[c][k];
  endfunction

  function automatic logic [W-1:0] rand_lw();
    logic [W-1:0] v;
    for (int k = 0; k < L; k++) v[B*k +: B] = B'($urandom);
    return v;
  endfunction

  function automatic logic [W-1:0] seed_lw(input int s);
    logic [W-1:0] v;
    for (int k = 0; k < L; k++) v[B*k +: B] = B'(s + lane_off[k]);
    return v;
  endfunction

  // Drive bits first..last of one word MSB first; at the word's last bit push the expected
  // parallel word, built from the last B bits of each lane's delayed stream.
  task automatic send_word(input logic [B-1:0] fw, input logic [W-1:0] lw, input bit must,
                           input int first = 0, input int last = B-1,
                           input int ld_at = -1, input logic [TW-1:0] ld_val = '0);
    for (int b = first; b <= last; b++) begin
      int t;
      @(negedge sys_clk);
      t = edge_n + 1;
      adclk_i = fw[B-1-b];
      for (int k = 0; k < L; k++) dat_i[k] = lw[B*k + B-1-b];
      in_h[t] = dat_i;
      for (int k = 0; k < L; k++)
        d_h[t][k] = (t - cur_tap[k] >= 0) ? in_h[t - cur_tap[k]][k] : 1'b0;
      idelay_ld_i = (b == ld_at);
      if (b == ld_at) begin
        idelay_val_i = ld_val;
        for (int k = 0; k < L; k++) cur_tap[k] = int'(ld_val[5*k +: 5]);
      end
      if (b == B-1) begin
        logic [W-1:0] e;
        for (int k = 0; k < L; k++)
          for (int i = 0; i < B; i++) e[B*k + B-1-i] = get_d(t - (B-1) + i, k);
        sbq.push_back('{t, e, must});
      end
    end
  endtask

  // Monitor: every locked output must be the word whose last bit landed one edge earlier.
  always @(negedge sys_clk) begin : mon
    int m;
    m = edge_n;
    if (sys_rst_n && data_valid_o && bitslip_done) begin
      while (sbq.size() > 0 && sbq[0].n < m - 1) begin
        if (sbq[0].must) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_drop: word ending at edge %0d had no locked output, required %0h", sbq[0].n, sbq[0].exp_w);
        end
        sbq.delete(0);
      end
      if (sbq.size() > 0 && sbq[0].n == m - 1) begin
        check("sb_word", data_o, sbq[0].exp_w);
        sbq.delete(0);
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexp: locked output at edge %0d got %0h, required no output", m, data_o);
      end
    end
  end

  initial begin
    logic [W-1:0]  w1, w2, w3, w5;
    logic [B-1:0]  a, b2;
    logic [TW-1:0] tv;
    int            p, left;

    for (int i = 0; i < HD; i++) begin
      in_h[i] = '0;
      d_h[i]  = '0;
    end
    for (int k = 0; k < L; k++) cur_tap[k] = 0;

    // Reset state, then lock from an arbitrary frame phase with lanes at zero.
    repeat (3) @(negedge sys_clk);
    check("rst_data", data_o, W'(0));
    check("rst_valid", W'(data_valid_o), W'(0));
    check("rst_done", W'(bitslip_done), W'(0));
    #1 sys_rst_n = 1'b1;
    p = $urandom_range(0, B-1);
    if (p > 0) send_word(PAT, '0, 1'b0, B - p);
    repeat (4) send_word(PAT, '0, 1'b0);
    check("lock_4words", W'(bitslip_done), W'(1));
    check("lock_data_zero", data_o, W'(0));

    // Counting seeds: each output is the previous seed's words.
    for (int s = 1; s <= 1006; s++) begin
      send_word(PAT, seed_lw(s), 1'b1);
      if (s == 6) begin
        check("seed5_lane0", W'(data_o[0 +: B]), W'(5));
        check("seed5_lane7", W'(data_o[B*7 +: B]), W'(22));
      end
    end
    repeat (40) send_word(PAT, rand_lw(), 1'b1);

    // One corrupted frame word is tolerated.
    send_word('0, rand_lw(), 1'b1);
    send_word(PAT, rand_lw(), 1'b1);
    check("one_bad_hold", W'(bitslip_done), W'(1));
    repeat (3) send_word(PAT, rand_lw(), 1'b1);

    // Two corrupted frame words drop lock; good frames relock within 3 words.
    send_word('0, rand_lw(), 1'b1);
    send_word('0, rand_lw(), 1'b0);
    send_word(PAT, rand_lw(), 1'b0);
    check("two_bad_drop", W'(bitslip_done), W'(0));
    send_word(PAT, rand_lw(), 1'b0);
    send_word(PAT, rand_lw(), 1'b1);
    check("relock_3w", W'(bitslip_done), W'(1));
    repeat (5) send_word(PAT, rand_lw(), 1'b1);

    // Lane 3 tap 4: its words shift by 4 bits; lock is unaffected.
    tv = '0;
    tv[5*3 +: 5] = 5'd4;
    w1 = rand_lw();
    w2 = rand_lw();
    w3 = rand_lw();
    send_word(PAT, w1, 1'b1, 0, B-1, $urandom_range(0, B-1), tv);
    send_word(PAT, w2, 1'b1);
    send_word(PAT, w3, 1'b1);
    a  = w1[B*3 +: B];
    b2 = w2[B*3 +: B];
    check("tap4_lane3", W'(data_o[B*3 +: B]), W'({a[3:0], b2[B-1:4]}));
    check("tap4_lane0", W'(data_o[0 +: B]), W'(w2[0 +: B]));
    check("tap_keep_lock", W'(bitslip_done), W'(1));
    repeat (10) send_word(PAT, rand_lw(), 1'b1);
    send_word(PAT, rand_lw(), 1'b1, 0, B-1, $urandom_range(0, B-1), '0);
    w5 = rand_lw();
    send_word(PAT, w5, 1'b1);
    send_word(PAT, rand_lw(), 1'b1);
    check("tap0_lane3", W'(data_o[B*3 +: B]), W'(w5[B*3 +: B]));
    repeat (5) send_word(PAT, rand_lw(), 1'b1);

    // Reset pulse mid-word while locked.
    check("pre_rst_done", W'(bitslip_done), W'(1));
    p = $urandom_range(1, B-2);
    w1 = rand_lw();
    send_word(PAT, w1, 1'b0, 0, p - 1);
    #1 sys_rst_n = 1'b0;
    #1;
    check("midrst_data", data_o, W'(0));
    check("midrst_valid", W'(data_valid_o), W'(0));
    check("midrst_done", W'(bitslip_done), W'(0));
    sbq.delete();
    idelay_val_i = '0;
    for (int k = 0; k < L; k++) cur_tap[k] = 0;
    send_word(PAT, w1, 1'b0, p);
    send_word(PAT, rand_lw(), 1'b0);
    #1 sys_rst_n = 1'b1;
    repeat (3) send_word(PAT, rand_lw(), 1'b0);
    send_word(PAT, rand_lw(), 1'b1);
    check("rst_relock_4w", W'(bitslip_done), W'(1));
    repeat (20) send_word(PAT, rand_lw(), 1'b1);
    repeat (2) send_word(PAT, rand_lw(), 1'b0);

    // Any required word still queued never came out locked.
    left = 0;
    foreach (sbq[i]) if (sbq[i].must && sbq[i].n < edge_n - 1) left++;
    check("sb_leftover", W'(left), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
